// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide co-unit.
// Shift-add multiply and restoring divide, one result bit per cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]      op_q;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nx;
  logic [XLEN-1:0] mcand;
  logic            neg_q;
  logic            neg_r;

  logic            in_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] spec_val;

  // request decode: sign flags, magnitudes, divide special cases
  always_comb begin
    in_div = funct3[2];
    sgn_a = in_div ? ~funct3[0]
                   : (funct3 == 3'b001) || (funct3 == 3'b010);
    sgn_b = in_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg = sgn_a & operand_a[XLEN-1];
    b_neg = sgn_b & operand_b[XLEN-1];
    mag_a = a_neg ? -operand_a : operand_a;
    mag_b = b_neg ? -operand_b : operand_b;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    b_zero = (operand_b == '0);
    ovf = sgn_a & (operand_a == min_val) & (operand_b == '1);
    special = in_div & (b_zero | ovf);
    spec_val = '0;
    if (b_zero) begin
      spec_val = funct3[1] ? operand_a : '1;
    end else begin
      spec_val = funct3[1] ? '0 : min_val;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = special ? FIX : RUN;
      RUN:  if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;

  assign acc_hi = acc[PW-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];

  // acc holds {product hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    addend = acc[0] ? mcand : '0;
    mul_sum = {1'b0, acc_hi} + {1'b0, addend};
    div_sh = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand};
    if (op_q[2]) begin
      if (div_diff[XLEN]) begin
        acc_nx = {div_sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
      end else begin
        acc_nx = {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nx = {mul_sum, acc_lo[XLEN-1:1]};
    end
  end

  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fix_val;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_fix = neg_q ? -acc_lo : acc_lo;
    r_fix = neg_r ? -acc_hi : acc_hi;
    fix_val = '0;
    unique case (op_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[PW-1:XLEN];
      3'b100, 3'b101:         fix_val = q_fix;
      3'b110, 3'b111:         fix_val = r_fix;
      default:                fix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= funct3;
            cnt  <= '0;
            // special cases park the answer in both halves, unsigned
            if (special) begin
              acc   <= {spec_val, spec_val};
              mcand <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (in_div) begin
              acc   <= {{XLEN{1'b0}}, mag_a};
              mcand <= mag_b;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag_b};
              mcand <= mag_a;
              neg_q <= a_neg ^ b_neg;
              neg_r <= 1'b0;
            end
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + ONE;
        end
        FIX: result <= fix_val;
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: XLEN=32 and XLEN=64 instances checked against
// an arithmetic reference model with directed and random operations.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s32, s64;
  logic [2:0]  f32, f64;
  logic [31:0] a32, b32, r32;
  logic [63:0] a64, b64, r64;
  logic        busy32, done32, busy64, done64;

  int n_checks = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .start(s32), .funct3(f32),
    .operand_a(a32), .operand_b(b32),
    .busy(busy32), .done(done32), .result(r32)
  );

  muldiv_unit #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .start(s64), .funct3(f64),
    .operand_a(a64), .operand_b(b64),
    .busy(busy64), .done(done64), .result(r64)
  );

  function automatic logic [63:0] ref_model(
    input int xl, input logic [2:0] f,
    input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ua, ub, sa, sb, p, t;
    logic [63:0] mask;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ua = {64'b0, a & mask};
    ub = {64'b0, b & mask};
    sa = ua;
    sb = ub;
    if (a[xl-1]) sa = ua - (128'sd1 <<< xl);
    if (b[xl-1]) sb = ub - (128'sd1 <<< xl);
    t = '0;
    case (f)
      3'b000: begin p = ua * ub; t = p; end
      3'b001: begin p = sa * sb; t = p >>> xl; end
      3'b010: begin p = sa * ub; t = p >>> xl; end
      3'b011: begin p = ua * ub; t = p >>> xl; end
      default: begin
        if (ub == 0) t = f[1] ? ua : -128'sd1;
        else case (f)
          3'b100: t = sa / sb;
          3'b101: t = ua / ub;
          3'b110: t = sa % sb;
          default: t = ua % ub;
        endcase
      end
    endcase
    return t[63:0] & mask;
  endfunction

  function automatic int exp_lat(
    input int xl, input logic [2:0] f,
    input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = 64'd1 << (xl - 1);
    if (f[2] && ((b & mask) == 0)) return 2;
    if ((f == 3'b100 || f == 3'b110) && (a & mask) == minv && (b & mask) == mask)
      return 2;
    return xl + 2;
  endfunction

  function automatic logic [63:0] rand_opnd(input bit w);
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = w ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      4: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    if (!w) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic issue(
    input bit w, input logic [2:0] f,
    input logic [63:0] a, input logic [63:0] b, input int poke,
    output logic [63:0] r, output int lat,
    output bit both, output bit gap, output bit held);
    logic [63:0] r0, cr;
    logic cb, cd;
    lat = 0;
    both = 0;
    gap = 0;
    held = 1;
    if (w ? done64 : done32) begin
      @(posedge clk);
      #1;
    end
    r0 = w ? r64 : {32'b0, r32};
    cr = r0;
    if (w) begin
      s64 = 1'b1; f64 = f; a64 = a; b64 = b;
    end else begin
      s32 = 1'b1; f32 = f; a32 = a[31:0]; b32 = b[31:0];
    end
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      s32 = !w && (lat == poke);
      s64 = w && (lat == poke);
      f32 = 3'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      f64 = 3'($urandom);
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      cb = w ? busy64 : busy32;
      cd = w ? done64 : done32;
      cr = w ? r64 : {32'b0, r32};
      if (cb && cd) both = 1;
      if (cd) break;
      if (!cb) gap = 1;
      if (cr !== r0) held = 0;
      if (lat >= 300) begin
        lat = -1;
        break;
      end
    end
    s32 = 1'b0;
    s64 = 1'b0;
    r = cr;
  endtask

  task automatic test_reset();
    logic [63:0] r;
    int lat;
    bit both, gap, held;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({busy32, done32, r32} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_state32: got busy=%b done=%b res=%h required 0 0 0",
               busy32, done32, r32);
    end
    n_checks++;
    if ({busy64, done64, r64} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state64: got busy=%b done=%b res=%h required 0 0 0",
               busy64, done64, r64);
    end
    issue(0, 3'b000, 64'd7, 64'hFFFF_FFFD, 0, r, lat, both, gap, held);
    n_checks++;
    if (r !== 64'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL pre_reset_mul: got %h required ffffffeb", r);
    end
    @(posedge clk);
    #1;
    s32 = 1'b1; f32 = 3'b011; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    s32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({busy32, done32, r32} !== 34'd0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got busy=%b done=%b res=%h required 0 0 0",
               busy32, done32, r32);
    end
    both = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32 || busy32) both = 1;
    end
    n_checks++;
    if (both !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got activity=%b required 0", both);
    end
    issue(0, 3'b101, 64'd100, 64'd7, 0, r, lat, both, gap, held);
    n_checks++;
    if (r !== 64'd14 || lat != 34) begin
      n_fail++;
      $display("FAIL post_reset_op: got %h lat %0d required e lat 34", r, lat);
    end
  endtask

  task automatic run_table(input string nm, input bit w, input int n,
    input logic [2:0] tf [8], input logic [63:0] ta [8],
    input logic [63:0] tb [8], input logic [63:0] tr [8], input int tl);
    logic [63:0] r;
    int lat;
    bit both, gap, held;
    for (int i = 0; i < n; i++) begin
      issue(w, tf[i], ta[i], tb[i], 0, r, lat, both, gap, held);
      n_checks++;
      if (r !== tr[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] result: got %h required %h", nm, i, r, tr[i]);
      end
      n_checks++;
      if (lat != tl || both || gap) begin
        n_fail++;
        $display("FAIL %s[%0d] timing: got lat=%0d both=%b gap=%b required lat=%0d 0 0",
                 nm, i, lat, both, gap, tl);
      end
    end
  endtask

  task automatic test_mul_signs();
    logic [2:0] tf [8];
    logic [63:0] ta [8], tb [8], tr [8];
    tf = '{3'b000, 3'b001, 3'b011, 3'b010, 0, 0, 0, 0};
    ta = '{64'd7, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 0, 0};
    tb = '{64'hFFFF_FFFD, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 0, 0};
    tr = '{64'hFFFF_FFEB, 64'h4000_0000, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 0, 0, 0, 0};
    run_table("mul", 0, 4, tf, ta, tb, tr, 34);
  endtask

  task automatic test_div_signs();
    logic [2:0] tf [8];
    logic [63:0] ta [8], tb [8], tr [8];
    tf = '{3'b100, 3'b110, 3'b101, 3'b111, 0, 0, 0, 0};
    ta = '{64'hFFFF_FFEC, 64'hFFFF_FFEC, 64'd100, 64'd100, 0, 0, 0, 0};
    tb = '{64'd3, 64'd3, 64'd7, 64'd7, 0, 0, 0, 0};
    tr = '{64'hFFFF_FFFA, 64'hFFFF_FFFE, 64'd14, 64'd2, 0, 0, 0, 0};
    run_table("div", 0, 4, tf, ta, tb, tr, 34);
  endtask

  task automatic test_special();
    logic [2:0] tf [8];
    logic [63:0] ta [8], tb [8], tr [8];
    tf = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110, 0, 0};
    ta = '{64'd5, 64'd5, 64'h8000_0000, 64'h8000_0000, 64'd9, 64'hFFFF_FFF7, 0, 0};
    tb = '{64'd0, 64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'd0, 0, 0};
    tr = '{64'hFFFF_FFFF, 64'd5, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF,
           64'hFFFF_FFF7, 0, 0};
    run_table("special", 0, 6, tf, ta, tb, tr, 2);
  endtask

  task automatic test_ignore_start();
    logic [63:0] r;
    int lat;
    bit both, gap, held;
    issue(0, 3'b001, 64'hDEAD_BEEF, 64'h1357_9BDF, 5, r, lat, both, gap, held);
    n_checks++;
    if (r !== ref_model(32, 3'b001, 64'hDEAD_BEEF, 64'h1357_9BDF) || lat != 34) begin
      n_fail++;
      $display("FAIL ignore_start: got %h lat %0d required %h lat 34", r, lat,
               ref_model(32, 3'b001, 64'hDEAD_BEEF, 64'h1357_9BDF));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int lat;
    bit both, gap, held;
    issue(0, 3'b000, 64'd6, 64'd7, 0, r, lat, both, gap, held);
    n_checks++;
    if (r !== 64'd42) begin
      n_fail++;
      $display("FAIL b2b_first: got %h required 2a", r);
    end
    issue(0, 3'b101, 64'd1000, 64'd9, 0, r, lat, both, gap, held);
    n_checks++;
    if (r !== 64'd111 || lat != 34) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat %0d required 6f lat 34", r, lat);
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result_held: got held=%b required 1", held);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (r32 !== 32'd111 || done32 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got res=%h done=%b required 6f 0", r32, done32);
    end
  endtask

  task automatic test_random(input bit w, input int n);
    logic [63:0] r, a, b, e;
    logic [2:0] f;
    int lat, xl, el;
    bit both, gap, held;
    xl = w ? 64 : 32;
    for (int i = 0; i < n; i++) begin
      f = 3'($urandom);
      a = rand_opnd(w);
      b = rand_opnd(w);
      e = ref_model(xl, f, a, b);
      el = exp_lat(xl, f, a, b);
      issue(w, f, a, b, 0, r, lat, both, gap, held);
      n_checks++;
      if (r !== e || lat != el || both) begin
        n_fail++;
        $display("FAIL rand%0d[%0d] f=%0d a=%h b=%h: got %h lat %0d required %h lat %0d",
                 xl, i, f, a, b, r, lat, e, el);
      end
    end
  endtask

  task automatic test_xlen64();
    logic [2:0] tf [8];
    logic [63:0] ta [8], tb [8], tr [8];
    tf = '{3'b011, 3'b100, 3'b110, 3'b000, 0, 0, 0, 0};
    ta = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7,
           64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0};
    tb = '{64'd2, 64'd2, 64'd2, 64'd3, 0, 0, 0, 0};
    tr = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0, 0};
    run_table("x64", 1, 4, tf, ta, tb, tr, 66);
  endtask

  initial begin
    rst = 1'b1;
    s32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
    s64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
    test_reset();
    test_mul_signs();
    test_div_signs();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_random(0, 60);
    test_xlen64();
    test_random(1, 12);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
